// File: rtl/seven_seg_mux_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: hex-to-segment table,
// the all-off segment pattern and the digit index width helper.
package seven_seg_pkg;

  // Active-low segment pattern {g,f,e,d,c,b,a} with every segment dark
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low patterns for hex values 0..F; element 0 is the rightmost entry
  localparam logic [15:0][6:0] HEX7_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  // Width of the digit index; never narrower than one bit
  function automatic int idx_width(input int num_digits);
    if (num_digits > 1) begin
      return $clog2(num_digits);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/seven_seg_mux_scanner_if.sv
// Digit bus and display pin bundle between the datapath and the scanner.
// master: datapath side (drives values/controls, observes pins).
// slave:  scanner side (consumes values, drives anode/segment pins).
interface seven_seg_mux_scanner_if import seven_seg_pkg::*; #(
  parameter int NUM_DIGITS = 4
) ();

  localparam int IDX_W = idx_width(NUM_DIGITS);

  logic                    enable;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              seg;
  logic                    dp;
  logic [IDX_W-1:0]        digit_idx;

  modport master (
    output enable, digits, dp_in, blank,
    input  anode, seg, dp, digit_idx
  );

  modport slave (
    input  enable, digits, dp_in, blank,
    output anode, seg, dp, digit_idx
  );

endinterface

// File: rtl/seven_seg_mux_scanner_hex_to_seg7.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
module hex_to_seg7 import seven_seg_pkg::*; (
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for the hex value
  always_comb begin
    seg = HEX7_TABLE[value];
  end

endmodule

// File: rtl/seven_seg_mux_scanner.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// A prescaler sets the dwell per digit; the first GUARD cycles of each dwell
// keep all anodes off to avoid ghosting. All pin outputs are registered.
// Optional build macro LEADING_ZERO_BLANK_EN: darkens zero digits above the
// highest non-zero digit (digit 0 always stays lit).
module seven_seg_mux_scanner import seven_seg_pkg::*; #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 100000,
  parameter int GUARD      = 0
) (
  input logic                    clock,
  input logic                    reset,
  seven_seg_mux_scanner_if.slave bus
);

  localparam int               IDX_W     = idx_width(NUM_DIGITS);
  localparam int               CNT_W     = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      count_r;
  logic [IDX_W-1:0]      idx_r;
  logic [3:0]            cur_value_s;
  logic [6:0]            dec_seg_s;
  logic                  in_guard_s;
  logic                  suppressed_s;
  logic                  dark_s;
  logic [NUM_DIGITS-1:0] anode_s;
  logic [6:0]            seg_s;
  logic                  dp_s;
  logic [NUM_DIGITS-1:0] anode_r;
  logic [6:0]            seg_r;
  logic                  dp_r;

  // Prescaler and digit index; both freeze while the scan is disabled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {CNT_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else if (bus.enable) begin
      if (count_r == CNT_LAST) begin
        count_r <= {CNT_W{1'b0}};
        if (idx_r == IDX_LAST) begin
          idx_r <= {IDX_W{1'b0}};
        end else begin
          idx_r <= idx_r + IDX_W'(1);
        end
      end else begin
        count_r <= count_r + CNT_W'(1);
        idx_r   <= idx_r;
      end
    end else begin
      count_r <= count_r;
      idx_r   <= idx_r;
    end
  end

  // Guard window at the start of each dwell; absent entirely when GUARD is 0
  generate
    if (GUARD > 0) begin : g_guard
      localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
      assign in_guard_s = (count_r < CNT_GUARD);
    end else begin : g_no_guard
      assign in_guard_s = 1'b0;
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_run_s;

  // zero_run_s[i] is set when digit i and every digit above it are zero
  always_comb begin
    zero_run_s = {NUM_DIGITS{1'b0}};
    zero_run_s[NUM_DIGITS-1] = (bus.digits[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_run_s[i] = zero_run_s[i+1] & (bus.digits[4*i +: 4] == 4'h0);
    end
  end

  // Digit 0 is always shown so a zero value never leaves the display blank
  assign suppressed_s = zero_run_s[idx_r] & (idx_r != {IDX_W{1'b0}});
`else
  assign suppressed_s = 1'b0;
`endif

  assign cur_value_s = bus.digits[{idx_r, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .value (cur_value_s),
    .seg   (dec_seg_s)
  );

  // Next pin values: either fully dark or exactly one anode pulled low
  always_comb begin
    dark_s  = !bus.enable || in_guard_s || bus.blank[idx_r] || suppressed_s;
    anode_s = {NUM_DIGITS{1'b1}};
    seg_s   = SEG_OFF;
    dp_s    = 1'b1;
    if (dark_s) begin
      anode_s = {NUM_DIGITS{1'b1}};
      seg_s   = SEG_OFF;
      dp_s    = 1'b1;
    end else begin
      anode_s[idx_r] = 1'b0;
      seg_s          = dec_seg_s;
      dp_s           = ~bus.dp_in[idx_r];
    end
  end

  // Pin registers; reset leaves the display dark
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anode_r <= {NUM_DIGITS{1'b1}};
      seg_r   <= SEG_OFF;
      dp_r    <= 1'b1;
    end else begin
      anode_r <= anode_s;
      seg_r   <= seg_s;
      dp_r    <= dp_s;
    end
  end

  assign bus.anode     = anode_r;
  assign bus.seg       = seg_r;
  assign bus.dp        = dp_r;
  assign bus.digit_idx = idx_r;

endmodule

// File: tb/tb_seven_seg_mux_scanner.sv
// Directed bench for seven_seg_mux_scanner with NUM_DIGITS=4, PRESCALE=4,
// GUARD=1. Expectations for LEADING_ZERO_BLANK_EN follow the same macro.
module tb_seven_seg_mux_scanner;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  seven_seg_mux_scanner_if #(.NUM_DIGITS(4)) bus_if ();

  seven_seg_mux_scanner #(
    .NUM_DIGITS (4),
    .PRESCALE   (4),
    .GUARD      (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    string           name;
    logic [15:0]     digits;
    logic [3:0]      dp_in;
    logic [3:0]      blank;
    logic [3:0][6:0] seg;    // expected segments per slot (index = digit)
    logic [3:0]      dark;   // slots expected dark for their whole dwell
    logic [3:0]      dp;     // expected active-low dp per slot when lit
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] anode_for(input int slot);
    case (slot)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic chk_pins(input string name, input logic [3:0] an, input logic [6:0] sg,
                          input logic d, input int idx);
    chk({name, " anode"}, 32'(bus_if.anode), 32'(an));
    chk({name, " seg"},   32'(bus_if.seg),   32'(sg));
    chk({name, " dp"},    32'(bus_if.dp),    32'(d));
    chk({name, " idx"},   32'(bus_if.digit_idx), 32'(idx));
  endtask

  task automatic apply_reset(input string name);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk_pins({name, " reset"}, 4'b1111, 7'h7F, 1'b1, 0);
    reset = 1'b1;
  endtask

  // Sample n (1-based) after release reflects state count=(n-1)%4, slot=(n-1)/4
  task automatic run_vec(input vec_t v, input int ncyc);
    for (int n = 1; n <= ncyc; n++) begin
      int   slot;
      logic lit;
      @(negedge clock);
      slot = ((n - 1) / 4) % 4;
      lit  = (((n - 1) % 4) != 0) && !v.dark[slot];
      chk_pins($sformatf("%s c%0d", v.name, n),
               lit ? anode_for(slot) : 4'b1111,
               lit ? v.seg[slot] : 7'h7F,
               lit ? v.dp[slot] : 1'b1,
               (n / 4) % 4);
    end
  endtask

  task automatic load(input vec_t v);
    bus_if.digits = v.digits;
    bus_if.dp_in  = v.dp_in;
    bus_if.blank  = v.blank;
  endtask

  initial begin
    bus_if.enable = 1'b1;
    bus_if.digits = 16'h0000;
    bus_if.dp_in  = 4'b0000;
    bus_if.blank  = 4'b0000;

    vecs.push_back('{"cnt1234", 16'h1234, 4'b0000, 4'b0000,
                     {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000, 4'b1111});
    vecs.push_back('{"blank2", 16'h1234, 4'b0000, 4'b0100,
                     {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0100, 4'b1111});
    vecs.push_back('{"dpABCD", 16'hABCD, 4'b0001, 4'b0000,
                     {7'h08, 7'h03, 7'h46, 7'h21}, 4'b0000, 4'b1110});
    vecs.push_back('{"mixF80E", 16'hF80E, 4'b1010, 4'b0001,
                     {7'h0E, 7'h00, 7'h40, 7'h06}, 4'b0001, 4'b0101});
`ifdef LEADING_ZERO_BLANK_EN
    vecs.push_back('{"lz0050", 16'h0050, 4'b0000, 4'b0000,
                     {7'h40, 7'h40, 7'h12, 7'h40}, 4'b1100, 4'b1111});
    vecs.push_back('{"lz0000", 16'h0000, 4'b0000, 4'b0000,
                     {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1110, 4'b1111});
    vecs.push_back('{"lz0900", 16'h0900, 4'b0000, 4'b0000,
                     {7'h40, 7'h10, 7'h40, 7'h40}, 4'b1000, 4'b1111});
`else
    vecs.push_back('{"lz0050", 16'h0050, 4'b0000, 4'b0000,
                     {7'h40, 7'h40, 7'h12, 7'h40}, 4'b0000, 4'b1111});
    vecs.push_back('{"lz0000", 16'h0000, 4'b0000, 4'b0000,
                     {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, 4'b1111});
    vecs.push_back('{"lz0900", 16'h0900, 4'b0000, 4'b0000,
                     {7'h40, 7'h10, 7'h40, 7'h40}, 4'b0000, 4'b1111});
`endif

    // Full scan of every table entry, including the 3->0 wrap at sample 16
    foreach (vecs[k]) begin
      load(vecs[k]);
      apply_reset(vecs[k].name);
      run_vec(vecs[k], 17);
    end

    // Input changes reach the pins one clock later
    load(vecs[0]);
    apply_reset("lat");
    run_vec(vecs[0], 2);
    bus_if.digits = 16'h1235;
    @(negedge clock);
    chk_pins("lat digit", 4'b1110, 7'h12, 1'b1, 0);
    bus_if.blank = 4'b0001;
    @(negedge clock);
    chk_pins("lat blank", 4'b1111, 7'h7F, 1'b1, 1);
    bus_if.blank = 4'b0000;

    // Enable dropped mid digit 1 for 10 cycles, then the dwell resumes
    load(vecs[0]);
    apply_reset("ena");
    run_vec(vecs[0], 6);
    bus_if.enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk_pins($sformatf("ena off%0d", k), 4'b1111, 7'h7F, 1'b1, 1);
    end
    bus_if.enable = 1'b1;
    @(negedge clock);
    chk_pins("ena r1", 4'b1101, 7'h30, 1'b1, 1);
    @(negedge clock);
    chk_pins("ena r2", 4'b1101, 7'h30, 1'b1, 2);
    @(negedge clock);
    chk_pins("ena r3", 4'b1111, 7'h7F, 1'b1, 2);
    @(negedge clock);
    chk_pins("ena r4", 4'b1011, 7'h24, 1'b1, 2);

    // Asynchronous reset between edges during digit 2
    load(vecs[0]);
    apply_reset("arst");
    run_vec(vecs[0], 10);
    #2;
    reset = 1'b0;
    #1;
    chk_pins("arst async", 4'b1111, 7'h7F, 1'b1, 0);
    @(negedge clock);
    reset = 1'b1;
    run_vec(vecs[0], 8);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
